// File: rtl/approx_mult_pipe_if.sv
// Operand/result handshake bundle for approx_mult_pipe.
// Both directions use valid/ready: a beat moves on a rising clk edge where valid && ready are both high.
// Once raised, valid and the payload must not change until that edge.
interface approx_mult_pipe_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               approx;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] z;
  logic               z_approx;

  // Upstream producer / downstream consumer side.
  modport master (
    output in_valid, x, y, approx, out_ready,
    input  in_ready, out_valid, z, z_approx
  );

  // Multiplier side.
  modport slave (
    input  in_valid, x, y, approx, out_ready,
    output in_ready, out_valid, z, z_approx
  );
endinterface

// File: rtl/approx_mult_pipe.sv
// Three-stage unsigned WIDTH x WIDTH multiplier with a per-transaction exact/approximate
// low-row mode and a count of accepted transactions.
module approx_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int SPLIT = 4,
  parameter int TRUNC = 6,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  approx_mult_pipe_if.slave  bus,
  output logic [CNT_W-1:0]   acc_cnt
);
  localparam int PW   = 2 * WIDTH;
  localparam int LO_W = WIDTH + SPLIT;
  localparam int HI_W = 2 * WIDTH - SPLIT;

  // Columns at or above TRUNC survive in approximate mode.
  localparam logic [PW-1:0]   KEEP_FULL = {PW{1'b1}} << TRUNC;
  localparam logic [LO_W-1:0] KEEP_LO   = KEEP_FULL[LO_W-1:0];

  // Each pair of low rows is OR-merged column-wise instead of added.
  // OR never exceeds the sum, so the result is bounded by the exact low sum.
  function automatic logic [LO_W-1:0] approx_lo(input logic [WIDTH-1:0] xv,
                                                input logic [WIDTH-1:0] yv);
    logic [LO_W-1:0] acc;
    logic [LO_W-1:0] y_ext;
    logic [LO_W-1:0] r0;
    logic [LO_W-1:0] r1;
    logic [1:0]      xs;
    acc   = '0;
    y_ext = LO_W'(yv);
    for (int k = 0; k < SPLIT / 2; k++) begin
      xs  = 2'(xv >> (2 * k));
      r0  = xs[0] ? (y_ext << (2 * k))     : '0;
      r1  = xs[1] ? (y_ext << (2 * k + 1)) : '0;
      acc = acc + ((r0 | r1) & KEEP_LO);
    end
    return acc;
  endfunction

  logic             stall;
  logic             accept;

  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             ap1_q, ap1_d;

  logic             s2_v_q, s2_v_d;
  logic [HI_W-1:0]  hi_q, hi_d;
  logic [LO_W-1:0]  lo_q, lo_d;
  logic             ap2_q, ap2_d;

  logic             s3_v_q, s3_v_d;
  logic [PW-1:0]    z_q, z_d;
  logic             za_q, za_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [HI_W-1:0]  hi_c;
  logic [LO_W-1:0]  lo_exact_c;
  logic [LO_W-1:0]  lo_apx_c;
  logic [PW-1:0]    z_c;

  // The whole pipe freezes only when a finished result is refused; otherwise every
  // stage advances each cycle, so empty stages never hold anything up.
  assign stall  = s3_v_q && !bus.out_ready;
  assign accept = bus.in_valid && !stall;

  assign hi_c       = HI_W'(y_q) * HI_W'(x_q[WIDTH-1:SPLIT]);
  assign lo_exact_c = LO_W'(y_q) * LO_W'(x_q[SPLIT-1:0]);
  assign lo_apx_c   = approx_lo(x_q, y_q);
  assign z_c        = (PW'(hi_q) << SPLIT) + PW'(lo_q);

  always_comb begin
    s1_v_d = s1_v_q;
    x_d    = x_q;
    y_d    = y_q;
    ap1_d  = ap1_q;
    s2_v_d = s2_v_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    ap2_d  = ap2_q;
    s3_v_d = s3_v_q;
    z_d    = z_q;
    za_d   = za_q;
    cnt_d  = cnt_q;
    if (!stall) begin
      s1_v_d = bus.in_valid;
      s2_v_d = s1_v_q;
      s3_v_d = s2_v_q;
      if (accept) begin
        x_d   = bus.x;
        y_d   = bus.y;
        ap1_d = bus.approx;
        cnt_d = cnt_q + 1'b1;
      end
      if (s1_v_q) begin
        hi_d  = hi_c;
        lo_d  = ap1_q ? lo_apx_c : lo_exact_c;
        ap2_d = ap1_q;
      end
      if (s2_v_q) begin
        z_d  = z_c;
        za_d = ap2_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      ap1_q  <= 1'b0;
      s2_v_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      ap2_q  <= 1'b0;
      s3_v_q <= 1'b0;
      z_q    <= '0;
      za_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      x_q    <= x_d;
      y_q    <= y_d;
      ap1_q  <= ap1_d;
      s2_v_q <= s2_v_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      ap2_q  <= ap2_d;
      s3_v_q <= s3_v_d;
      z_q    <= z_d;
      za_q   <= za_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.in_ready  = !stall;
  assign bus.out_valid = s3_v_q;
  assign bus.z         = z_q;
  assign bus.z_approx  = za_q;
  assign acc_cnt       = cnt_q;
endmodule
